// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Op codes mirror the ALU control unit encodings.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SQU = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the operand latches and the ALU.
// master drives requests, slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             illegal_op;

  modport master (
    output start, ALUOperation, A, B,
    input  busy, done, ALUResult, Zero, illegal_op
  );

  modport slave (
    input  start, ALUOperation, A, B,
    output busy, done, ALUResult, Zero, illegal_op
  );
endinterface

// File: rtl/alu_multicycle_squarer_iter.sv
// Iterative shift-add squarer, one multiplier bit per step.
// o_last flags the step that produces the final accumulator.
module alu_squarer_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_last
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_add;

  assign w_add      = r_mplr[0] ? r_mcand : '0;
  assign o_acc_next = r_acc + w_add;
  assign o_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_mplr  <= i_a;
      r_acc   <= '0;
      r_cnt   <= CW'(WIDTH);
    end else if (i_step) begin
      r_acc   <= o_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/add/move ops,
// multi-cycle square through the iterative squarer.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_multicycle_if.slave bus
);
  alu_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ill;

  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_accept;
  logic             w_is_squ;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && bus.start && !r_busy;
  assign w_is_squ = (bus.ALUOperation == ALU_SQU);
  assign w_load   = reset && w_accept && w_is_squ;
  assign w_step   = (r_state == EXEC);

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    unique case (1'b1)
      (bus.ALUOperation == ALU_AND): w_res = bus.A & bus.B;
      (bus.ALUOperation == ALU_OR):  w_res = bus.A | bus.B;
      (bus.ALUOperation == ALU_NOR): w_res = ~(bus.A | bus.B);
      (bus.ALUOperation == ALU_ADD): w_res = bus.A + bus.B;
      (bus.ALUOperation == ALU_MOV): w_res = bus.B;
      (bus.ALUOperation == ALU_SQU): w_res = '0;
      default:                       w_ill = 1'b1;
    endcase
  end

  alu_squarer_iter #(.WIDTH(WIDTH)) u_sq (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_a        (bus.A),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_ill   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept && w_is_squ) begin
            r_state <= EXEC;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_state <= DONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b1;
            r_res   <= w_res;
            r_zero  <= (w_res == '0);
            r_ill   <= w_ill;
          end
        end
        EXEC: begin
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_res   <= w_acc_next;
            r_zero  <= (w_acc_next == '0);
            r_ill   <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ALUResult  = r_res;
  assign bus.Zero       = r_zero;
  assign bus.illegal_op = r_ill;
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed cases,
// then random ops checked against an arithmetic model.
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n_done;
  int   n_issued;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  exp_t sb[$];

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(logic [3:0] op,
                                 logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    longint unsigned sq;
    e.ill = 1'b0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = ~(a | b);
      4'd3:  e.res = W'((64'(a) + 64'(b)) % (64'd1 << W));
      4'd4: begin
        sq = 64'(a) * 64'(a);
        e.res = sq[W-1:0];
      end
      4'd15: e.res = b;
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=%h required=none",
                 bus.ALUResult);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.ALUResult !== e.res || bus.Zero !== e.zero ||
            bus.illegal_op !== e.ill) begin
          errors++;
          $display("FAIL result actual=%h/%b/%b required=%h/%b/%b",
                   bus.ALUResult, bus.Zero, bus.illegal_op,
                   e.res, e.zero, e.ill);
        end
      end
    end
  end

  // Issue one op; optionally poke a start during busy at cycle inj.
  task automatic do_op(logic [3:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, int inj);
    int n;
    int lim;
    lim = 0;
    while (bus.busy !== 1'b0 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    bus.start = 1'b1;
    bus.ALUOperation = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    sb.push_back(model(op, a, b));
    n_issued++;
    #1;
    bus.start = 1'b0;
    bus.ALUOperation = 4'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == inj) begin
        bus.start = 1'b1;
        bus.ALUOperation = 4'd3;
      end else if (i == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1) break;
      n++;
    end
    chk("busy_len", W'(n), (op == 4'd4) ? W'(W + 1) : W'(1));
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_busy"}, W'(bus.busy), '0);
    chk({tag, "_done"}, W'(bus.done), '0);
    chk({tag, "_ill"},  W'(bus.illegal_op), '0);
    chk({tag, "_res"},  bus.ALUResult, '0);
    chk({tag, "_zero"}, W'(bus.Zero), W'(1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_done = 0;
    n_issued = 0;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.ALUOperation = 4'd3;
    bus.A = 32'd1;
    bus.B = 32'd1;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    do_op(4'd3, 32'd5, 32'd7, -1);
    do_op(4'd0, 32'h0000_00F0, 32'h0000_000F, -1);
    do_op(4'd2, 32'd0, 32'd0, -1);
    do_op(4'd15, 32'h1234_5678, 32'hDEAD_BEEF, -1);
    do_op(4'd4, 32'h0000_FFFF, 32'd0, -1);
    do_op(4'd4, 32'h0001_0000, 32'd0, -1);
    do_op(4'd9, 32'd3, 32'd4, -1);
    do_op(4'd3, 32'hFFFF_FFFF, 32'd2, -1);
    do_op(4'd4, 32'h0000_1234, 32'd0, 5);

    // Abort a square mid-flight; no result may ever appear.
    bus.start = 1'b1;
    bus.ALUOperation = 4'd4;
    bus.A = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("abort");
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_nodone", W'(n_done), W'(n_issued));

    do_op(4'd3, 32'd1, 32'd1, -1);

    for (int k = 0; k < 30; k++) begin
      logic [3:0] op;
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd3;
        4: op = 4'd4;
        5: op = 4'd15;
        default: op = 4'($urandom_range(5, 14));
      endcase
      do_op(op, $urandom, $urandom, -1);
    end

    repeat (5) @(negedge clk);
    chk("done_count", W'(n_done), W'(n_issued));
    chk("sb_empty", W'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
